// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter sharing one downstream valid/ready port between NumReq
// requesters. Grant is presented as a one-hot vector plus a binary index, can
// be locked while the downstream port stalls, and is guarded by a one-hot
// self-check feeding sticky error flags.
module onehot_rr_arbiter #(
  parameter int unsigned NumReq      = 4,
  parameter bit          LockIn      = 1'b1,
  parameter bit          CheckOnehot = 1'b1,
  // Derived; do not override.
  parameter int unsigned IdxW        = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic [NumReq-1:0] req_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [1:0]        err_o,
  input  logic              err_clr_i
);

  localparam logic [IdxW-1:0]   LastIdx = IdxW'(NumReq - 1);
  localparam logic [NumReq-1:0] GntOne  = NumReq'(1);

  // Architectural state
  logic [IdxW-1:0] r_rr;
  logic            r_lock;
  logic [IdxW-1:0] r_lock_idx;
  logic [1:0]      r_err;

  // Next-state values
  logic [IdxW-1:0] w_rr_d;
  logic            w_lock_d;
  logic [IdxW-1:0] w_lock_idx_d;
  logic [1:0]      w_err_d;

  // Arbitration results
  logic            w_scan_found;
  logic [IdxW-1:0] w_scan_idx;
  logic [IdxW-1:0] w_scan_cand;
  logic            w_valid;
  logic [IdxW-1:0] w_idx;
  logic [NumReq-1:0] w_gnt;
  logic            w_withdraw;
  logic            w_transfer;
  logic            w_stall;
  logic [IdxW-1:0] w_idx_next;
  logic            w_onehot_err;

  // Rotating priority scan starting at the round-robin pointer.
  always_comb begin
    w_scan_found = 1'b0;
    w_scan_idx   = '0;
    w_scan_cand  = r_rr;
    for (int k = 0; k < int'(NumReq); k++) begin
      if (!w_scan_found && req_i[w_scan_cand]) begin
        w_scan_found = 1'b1;
        w_scan_idx   = w_scan_cand;
      end
      w_scan_cand = (w_scan_cand == LastIdx) ? '0 : w_scan_cand + IdxW'(1);
    end
  end

  // Select between the locked requester and the fresh scan result; build grant.
  always_comb begin
    w_valid    = 1'b0;
    w_idx      = '0;
    w_withdraw = 1'b0;
    w_gnt      = '0;
    if (r_lock) begin
      // While locked, only the held requester is considered.
      w_valid    = req_i[r_lock_idx];
      w_idx      = r_lock_idx;
      w_withdraw = !req_i[r_lock_idx];
    end else begin
      w_valid = w_scan_found;
      w_idx   = w_scan_idx;
    end
    if (w_valid) begin
      w_gnt[w_idx] = 1'b1;
    end
  end

  assign gnt_o   = w_gnt;
  assign idx_o   = w_valid ? w_idx : '0;
  assign valid_o = w_valid;

  // Handshake qualifiers; ready_i only reaches state, never the outputs.
  assign w_transfer = w_valid && ready_i;
  assign w_stall    = w_valid && !ready_i && LockIn;
  assign w_idx_next = (w_idx == LastIdx) ? '0 : w_idx + IdxW'(1);

  // One-hot self-check on the grant vector.
  if (CheckOnehot) begin : g_onehot_chk
    logic w_is_onehot;
    assign w_is_onehot  = (|w_gnt) && ((w_gnt & (w_gnt - GntOne)) == '0);
    assign w_onehot_err = w_valid && !w_is_onehot;
  end else begin : g_no_onehot_chk
    assign w_onehot_err = 1'b0;
  end

  // Pointer and lock next-state; flush overrides handshake updates.
  always_comb begin
    w_rr_d       = r_rr;
    w_lock_d     = r_lock;
    w_lock_idx_d = r_lock_idx;
    if (w_withdraw) begin
      // Pointer deliberately left alone: nothing was transferred.
      w_lock_d = 1'b0;
    end else if (w_transfer) begin
      w_rr_d   = w_idx_next;
      w_lock_d = 1'b0;
    end else if (w_stall) begin
      w_lock_d     = 1'b1;
      w_lock_idx_d = w_idx;
    end
    if (flush_i) begin
      w_rr_d   = '0;
      w_lock_d = 1'b0;
    end
  end

  // Sticky error next-state; a new event in the clear cycle keeps its bit set.
  always_comb begin
    w_err_d = err_clr_i ? 2'b00 : r_err;
    if (w_onehot_err) begin
      w_err_d[0] = 1'b1;
    end
    if (w_withdraw) begin
      w_err_d[1] = 1'b1;
    end
  end

  assign err_o = r_err;

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr       <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      r_err      <= 2'b00;
    end else begin
      r_rr       <= w_rr_d;
      r_lock     <= w_lock_d;
      r_lock_idx <= w_lock_idx_d;
      r_err      <= w_err_d;
    end
  end

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Self-checking bench for onehot_rr_arbiter: directed scenarios plus random
// traffic, compared against a behavioural model of the arbitration rules.
// Two instances share stimulus: one with grant locking, one without.
module tb_onehot_rr_arbiter;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic [N-1:0] req;
  logic         ready;
  logic         err_clr;

  logic [N-1:0] gnt_a, gnt_b;
  logic [1:0]   idx_a, idx_b;
  logic         valid_a, valid_b;
  logic [1:0]   err_a, err_b;

  int n_checks = 0;
  int n_errors = 0;

  // Model state per instance: [0] LockIn=1, [1] LockIn=0
  int       m_rr[2];
  bit       m_lock[2];
  int       m_lidx[2];
  bit [1:0] m_err[2];
  bit       m_lockin[2];

  onehot_rr_arbiter #(
    .NumReq     (N),
    .LockIn     (1'b1),
    .CheckOnehot(1'b1)
  ) u_dut_lock (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .flush_i  (flush),
    .req_i    (req),
    .gnt_o    (gnt_a),
    .idx_o    (idx_a),
    .valid_o  (valid_a),
    .ready_i  (ready),
    .err_o    (err_a),
    .err_clr_i(err_clr)
  );

  onehot_rr_arbiter #(
    .NumReq     (N),
    .LockIn     (1'b0),
    .CheckOnehot(1'b1)
  ) u_dut_nolock (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .flush_i  (flush),
    .req_i    (req),
    .gnt_o    (gnt_b),
    .idx_o    (idx_b),
    .valid_o  (valid_b),
    .ready_i  (ready),
    .err_o    (err_b),
    .err_clr_i(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_rr[i]   = 0;
      m_lock[i] = 1'b0;
      m_lidx[i] = 0;
      m_err[i]  = 2'b00;
    end
  endfunction

  // Who wins this cycle, from the round-robin rules.
  function automatic void model_pick(input int inst, output bit v, output int idx);
    v   = 1'b0;
    idx = 0;
    if (m_lock[inst]) begin
      v   = req[m_lidx[inst]];
      idx = m_lidx[inst];
    end else begin
      for (int k = 0; k < N; k++) begin
        int cand;
        cand = (m_rr[inst] + k) % N;
        if (!v && req[cand]) begin
          v   = 1'b1;
          idx = cand;
        end
      end
    end
  endfunction

  function automatic void model_step(input int inst, input bit v, input int idx);
    bit wd;
    wd = m_lock[inst] && !req[m_lidx[inst]];
    if (err_clr) m_err[inst] = 2'b00;
    if (wd) m_err[inst][1] = 1'b1;
    if (wd) begin
      m_lock[inst] = 1'b0;
    end else if (v && ready) begin
      m_rr[inst]   = (idx + 1) % N;
      m_lock[inst] = 1'b0;
    end else if (v && !ready && m_lockin[inst]) begin
      m_lock[inst] = 1'b1;
      m_lidx[inst] = idx;
    end
    if (flush) begin
      m_rr[inst]   = 0;
      m_lock[inst] = 1'b0;
    end
  endfunction

  task automatic drive(input logic [N-1:0] r, input logic rdy, input logic fl,
                       input logic clr);
    req     = r;
    ready   = rdy;
    flush   = fl;
    err_clr = clr;
  endtask

  // One clock: compare at the falling edge, advance the model, return after
  // the rising edge. Literal grant expectations of -1 are skipped.
  task automatic cycle(input int lit_a, input int lit_b);
    bit v;
    int idx;
    int exp_gnt;
    @(negedge clk);
    for (int inst = 0; inst < 2; inst++) begin
      model_pick(inst, v, idx);
      exp_gnt = v ? (1 << idx) : 0;
      if (inst == 0) begin
        check_eq("gnt_lock", int'(gnt_a), exp_gnt);
        check_eq("idx_lock", int'(idx_a), v ? idx : 0);
        check_eq("valid_lock", int'(valid_a), int'(v));
        check_eq("err_lock", int'(err_a), int'(m_err[0]));
      end else begin
        check_eq("gnt_nolock", int'(gnt_b), exp_gnt);
        check_eq("idx_nolock", int'(idx_b), v ? idx : 0);
        check_eq("valid_nolock", int'(valid_b), int'(v));
        check_eq("err_nolock", int'(err_b), int'(m_err[1]));
      end
      model_step(inst, v, idx);
    end
    if (lit_a >= 0) check_eq("lit_gnt_lock", int'(gnt_a), lit_a);
    if (lit_b >= 0) check_eq("lit_gnt_nolock", int'(gnt_b), lit_b);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive(4'b0000, 1'b0, 1'b0, 1'b0);
    model_reset();
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_lockin[0] = 1'b1;
    m_lockin[1] = 1'b0;
    rst_n = 1'b1;
    drive(4'b0000, 1'b0, 1'b0, 1'b0);
    #1;
    apply_reset();

    // Reset state
    cycle(0, 0);
    check_eq("reset_err", int'(err_a), 0);

    // Full request, always ready: plain rotation
    drive(4'b1111, 1'b1, 1'b0, 1'b0);
    cycle(1, 1);
    cycle(2, 2);
    cycle(4, 4);
    cycle(8, 8);
    cycle(1, 1);

    // Stall holds grant, then transfer, then rotate
    apply_reset();
    drive(4'b1010, 1'b0, 1'b0, 1'b0);
    cycle(2, -1);
    cycle(2, -1);
    cycle(2, -1);
    drive(4'b1111, 1'b1, 1'b0, 1'b0);
    cycle(2, -1);
    cycle(4, -1);
    // Pointer wrap after granting idx 3
    cycle(8, -1);
    drive(4'b0110, 1'b1, 1'b0, 1'b0);
    cycle(2, -1);

    // Withdraw while locked on idx 2
    drive(4'b0110, 1'b0, 1'b0, 1'b0);
    cycle(4, -1);
    drive(4'b0010, 1'b0, 1'b0, 1'b0);
    cycle(0, -1);
    drive(4'b0010, 1'b1, 1'b0, 1'b0);
    check_eq("withdraw_err", int'(err_a), 2);
    cycle(2, -1);
    drive(4'b0000, 1'b0, 1'b0, 1'b1);
    cycle(0, -1);
    drive(4'b0000, 1'b0, 1'b0, 1'b0);
    check_eq("err_clr", int'(err_a), 0);
    cycle(0, -1);

    // Build lock on idx 3 with rr=3 and err=10, then reset between edges
    drive(4'b0100, 1'b1, 1'b0, 1'b0);
    cycle(4, -1);
    drive(4'b1000, 1'b0, 1'b0, 1'b0);
    cycle(8, -1);
    drive(4'b0000, 1'b0, 1'b0, 1'b0);
    cycle(0, -1);
    drive(4'b1000, 1'b0, 1'b0, 1'b0);
    cycle(8, -1);
    check_eq("pre_rst_err", int'(err_a), 2);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_err", int'(err_a), 0);
    model_reset();
    #1;
    rst_n = 1'b1;
    drive(4'b1111, 1'b1, 1'b0, 1'b0);
    cycle(1, 1);

    // Flush during transfer of idx 1: pointer returns to 0, err preserved
    drive(4'b0000, 1'b0, 1'b0, 1'b0);
    cycle(0, 0);
    drive(4'b0010, 1'b1, 1'b1, 1'b0);
    cycle(2, 2);
    drive(4'b1111, 1'b1, 1'b0, 1'b0);
    cycle(1, 1);

    // No-lock build follows a changing request during a stall
    apply_reset();
    drive(4'b0100, 1'b0, 1'b0, 1'b0);
    cycle(4, 4);
    drive(4'b0010, 1'b0, 1'b0, 1'b0);
    cycle(-1, 2);
    check_eq("nolock_err", int'(err_b), 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      drive(4'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 15) == 0));
      cycle(-1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
